// File: rtl/vlsu_sequencer_if.sv
// Memory port of the vector load/store sequencer: a single ELEN-wide request
// channel with grant, plus a load-return channel.
interface vlsu_sequencer_if #(
   parameter int ELEN = 32
);
   logic            mem_req;
   logic            mem_we;
   logic [ELEN-1:0] mem_addr;
   logic [ELEN-1:0] mem_wdata;
   logic            mem_gnt;
   logic            mem_rvalid;
   logic [ELEN-1:0] mem_rdata;

   // mem_req with mem_we/mem_addr/mem_wdata is offered and held unchanged until a
   // cycle with mem_gnt=1 accepts it; load data comes back later as a single
   // mem_rvalid cycle carrying mem_rdata.
   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/vlsu_sequencer.sv
// Vector load/store sequencer: walks the active lanes in ascending order and
// issues one ELEN-wide memory access per lane, assembling load data into xdmem.
module vlsu_sequencer #(
   parameter  int VLEN = 128,
   parameter  int ELEN = 32,
   localparam int NL   = VLEN / ELEN,
   localparam int LW   = (NL > 1) ? $clog2(NL) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 is_store,
   input  logic [NL*ELEN-1:0]   lane_addr,
   input  logic [NL-1:0]        lane_vm,
   input  logic [VLEN-1:0]      st_data,
   vlsu_sequencer_if.master     mem,
   output logic                 busy,
   output logic                 done,
   output logic [VLEN-1:0]      xdmem,
   output logic [NL-1:0]        vwen,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [LW-1:0]       ptr_q, ptr_d;
   logic                st_q, st_d;
   logic [NL*ELEN-1:0]  addr_q, addr_d;
   logic [NL-1:0]       vm_q, vm_d;
   logic [VLEN-1:0]     data_q, data_d;
   logic [VLEN-1:0]     xdmem_q, xdmem_d;

   logic                first_found, next_found;
   logic [LW-1:0]       first_lane, next_lane;
   logic [ELEN-1:0]     cur_addr, cur_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         st_q    <= 1'b0;
         addr_q  <= '0;
         vm_q    <= '0;
         data_q  <= '0;
         xdmem_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         st_q    <= st_d;
         addr_q  <= addr_d;
         vm_q    <= vm_d;
         data_q  <= data_d;
         xdmem_q <= xdmem_d;
      end
   end

   // Lane search runs downward so the last hit is the lowest qualifying lane.
   always_comb begin
      first_found = 1'b0;
      first_lane  = '0;
      next_found  = 1'b0;
      next_lane   = '0;
      cur_addr    = '0;
      cur_wdata   = '0;
      for (int i = NL-1; i >= 0; i--) begin
         if (lane_vm[i]) begin
            first_found = 1'b1;
            first_lane  = LW'(i);
         end
         if (vm_q[i] && (LW'(i) > ptr_q)) begin
            next_found = 1'b1;
            next_lane  = LW'(i);
         end
      end
      for (int i = 0; i < NL; i++) begin
         if (LW'(i) == ptr_q) begin
            cur_addr  = addr_q[i*ELEN +: ELEN];
            cur_wdata = data_q[i*ELEN +: ELEN];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      st_d    = st_q;
      addr_d  = addr_q;
      vm_d    = vm_q;
      data_d  = data_q;
      xdmem_d = xdmem_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               st_d    = is_store;
               addr_d  = lane_addr;
               vm_d    = lane_vm;
               data_d  = st_data;
               xdmem_d = '0;
               if (first_found) begin
                  state_d = S_REQ;
                  ptr_d   = first_lane;
               end else begin
                  state_d = S_DONE;
                  ptr_d   = '0;
               end
            end
         end
         S_REQ: begin
            if (mem.mem_gnt) begin
               if (!st_q) begin
                  state_d = S_WAIT;
               end else if (next_found) begin
                  ptr_d = next_lane;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_WAIT: begin
            if (mem.mem_rvalid) begin
               for (int i = 0; i < NL; i++) begin
                  if (LW'(i) == ptr_q) begin
                     xdmem_d[i*ELEN +: ELEN] = mem.mem_rdata;
                  end
               end
               if (next_found) begin
                  state_d = S_REQ;
                  ptr_d   = next_lane;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            ptr_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // All outputs decode registered state only, so reset alone drives them to 0.
   assign mem.mem_req   = (state_q == S_REQ);
   assign mem.mem_we    = (state_q == S_REQ) && st_q;
   assign mem.mem_addr  = (state_q == S_REQ) ? cur_addr : '0;
   assign mem.mem_wdata = ((state_q == S_REQ) && st_q) ? cur_wdata : '0;

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign vwen      = ((state_q == S_DONE) && !st_q) ? vm_q : '0;
   assign xdmem     = xdmem_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_vlsu_sequencer.sv
// Bench for vlsu_sequencer: a memory responder with configurable stalls, and
// scenario tasks checking against a lane-list reference model.
module tb_vlsu_sequencer;
   localparam int VLEN = 128;
   localparam int ELEN = 32;
   localparam int NL   = VLEN / ELEN;

   typedef struct {
      logic [ELEN-1:0] addr;
      logic            we;
      logic [ELEN-1:0] wdata;
      logic            gnt;
   } req_t;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start;
   logic                is_store;
   logic [NL*ELEN-1:0]  lane_addr;
   logic [NL-1:0]       lane_vm;
   logic [VLEN-1:0]     st_data;
   logic                busy;
   logic                done;
   logic [VLEN-1:0]     xdmem;
   logic [NL-1:0]       vwen;
   logic [1:0]          dbg_state;

   vlsu_sequencer_if #(.ELEN(ELEN)) mem_if ();

   vlsu_sequencer #(.VLEN(VLEN), .ELEN(ELEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_store  (is_store),
      .lane_addr (lane_addr),
      .lane_vm   (lane_vm),
      .st_data   (st_data),
      .mem       (mem_if),
      .busy      (busy),
      .done      (done),
      .xdmem     (xdmem),
      .vwen      (vwen),
      .dbg_state (dbg_state)
   );

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   int start_cyc  = 0;

   int gnt_wait   = 0;
   int rv_delay   = 0;
   bit spurious   = 1'b0;
   int rv_cnt     = 0;
   int stall_cnt  = 0;
   logic [ELEN-1:0] rv_addr = '0;

   req_t                req_log[$];
   int                  done_lat_q[$];
   logic [NL-1:0]       vwen_q[$];
   logic [VLEN-1:0]     xdmem_q[$];

   logic [2*ELEN:0]     exp_q[$];
   logic [2*ELEN:0]     act_q[$];
   logic [VLEN-1:0]     exp_x;
   logic [NL-1:0]       exp_v;
   int                  exp_lat;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- memory model and monitor ----------------
   function automatic logic [ELEN-1:0] mem_rd(input logic [ELEN-1:0] a);
      if (a >= 32'h100 && a <= 32'h10C) return 32'hA0 + ((a - 32'h100) >> 2);
      return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
   endfunction

   function automatic logic [VLEN-1:0] rand_vec();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      mem_if.mem_gnt    = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_rdata  = '0;
      forever begin
         @(negedge clk);
         mem_if.mem_gnt    = 1'b0;
         mem_if.mem_rvalid = 1'b0;
         mem_if.mem_rdata  = '0;
         if (!rst_n) begin
            rv_cnt    = 0;
            stall_cnt = 0;
         end else begin
            if (rv_cnt > 0) begin
               rv_cnt--;
               if (rv_cnt == 0) begin
                  mem_if.mem_rvalid = 1'b1;
                  mem_if.mem_rdata  = mem_rd(rv_addr);
               end
            end
            if (mem_if.mem_req) begin
               if (stall_cnt < gnt_wait) begin
                  stall_cnt++;
                  if (spurious) begin
                     mem_if.mem_rvalid = 1'b1;
                     mem_if.mem_rdata  = 32'hDEADBEEF;
                  end
               end else begin
                  mem_if.mem_gnt = 1'b1;
                  stall_cnt = 0;
                  if (!mem_if.mem_we) begin
                     rv_cnt  = rv_delay + 1;
                     rv_addr = mem_if.mem_addr;
                  end
               end
               req_log.push_back('{mem_if.mem_addr, mem_if.mem_we, mem_if.mem_wdata, mem_if.mem_gnt});
            end
            if (done) begin
               done_lat_q.push_back(cyc - start_cyc);
               vwen_q.push_back(vwen);
               xdmem_q.push_back(xdmem);
            end
         end
      end
   end

   // ---------------- reference model ----------------
   // Expected accesses, load image, write enables and done cycle for one operation
   // when every request waits g cycles for grant and every load r extra cycles for data.
   task automatic model(input bit st, input logic [NL*ELEN-1:0] a, input logic [NL-1:0] vm,
                        input logic [VLEN-1:0] d, input int g, input int r);
      int n;
      n = 0;
      exp_q.delete();
      exp_x = '0;
      for (int i = 0; i < NL; i++) begin
         if (vm[i]) begin
            exp_q.push_back({st, a[i*ELEN +: ELEN], st ? d[i*ELEN +: ELEN] : {ELEN{1'b0}}});
            if (!st) exp_x[i*ELEN +: ELEN] = mem_rd(a[i*ELEN +: ELEN]);
            n++;
         end
      end
      exp_v   = st ? '0 : vm;
      exp_lat = 1 + n * (st ? (g + 1) : (g + 1 + r + 1));
   endtask

   // ---------------- drivers ----------------
   task automatic start_op(input bit st, input logic [NL*ELEN-1:0] a, input logic [NL-1:0] vm,
                           input logic [VLEN-1:0] d);
      @(negedge clk); #1;
      req_log.delete();
      done_lat_q.delete();
      vwen_q.delete();
      xdmem_q.delete();
      is_store  = st;
      lane_addr = a;
      lane_vm   = vm;
      st_data   = d;
      start     = 1'b1;
      start_cyc = cyc;
      @(negedge clk); #1;
      start     = 1'b0;
      is_store  = ~st;
      lane_addr = rand_vec();
      lane_vm   = ~vm;
      st_data   = rand_vec();
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (done_lat_q.size() > 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic collect_granted();
      act_q.delete();
      foreach (req_log[i]) begin
         if (req_log[i].gnt) act_q.push_back({req_log[i].we, req_log[i].addr, req_log[i].wdata});
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n     = 1'b0;
      start     = 1'b1;
      is_store  = 1'b1;
      lane_vm   = '1;
      lane_addr = rand_vec();
      st_data   = rand_vec();
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if ({busy, done, mem_if.mem_req, mem_if.mem_we} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags: busy/done/req/we=%b want 0000", {busy, done, mem_if.mem_req, mem_if.mem_we});
      end
      vectors++;
      if (mem_if.mem_addr !== '0 || mem_if.mem_wdata !== '0) begin
         miscompares++;
         $display("FAIL reset_bus: addr=%h wdata=%h want 0", mem_if.mem_addr, mem_if.mem_wdata);
      end
      vectors++;
      if (xdmem !== '0 || vwen !== '0) begin
         miscompares++;
         $display("FAIL reset_wb: xdmem=%h vwen=%b want 0", xdmem, vwen);
      end
      start = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic test_load_all();
      logic [NL*ELEN-1:0] a;
      logic [VLEN-1:0]    d;
      bit ok;
      gnt_wait = 0; rv_delay = 0; spurious = 1'b0;
      a = {32'h10C, 32'h108, 32'h104, 32'h100};
      d = rand_vec();
      model(1'b0, a, 4'hF, d, 0, 0);
      start_op(1'b0, a, 4'hF, d);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL load_all busy: got %b want 1", busy);
      end
      wait_done(100, ok);
      repeat (4) @(negedge clk);
      #1;
      vectors++;
      if (!ok || done_lat_q.size() != 1 || done_lat_q[0] != 9) begin
         miscompares++;
         $display("FAIL load_all done: pulses=%0d cycle=%0d want 1 pulse at 9", done_lat_q.size(),
                  (done_lat_q.size() > 0) ? done_lat_q[0] : -1);
      end
      vectors++;
      if (xdmem_q.size() != 1 || xdmem_q[0] !== 128'h000000A3_000000A2_000000A1_000000A0) begin
         miscompares++;
         $display("FAIL load_all xdmem: got %h want 000000a3000000a2000000a1000000a0",
                  (xdmem_q.size() > 0) ? xdmem_q[0] : '0);
      end
      vectors++;
      if (xdmem !== exp_x) begin
         miscompares++;
         $display("FAIL load_all xdmem_hold: got %h want %h", xdmem, exp_x);
      end
      vectors++;
      if (vwen_q.size() != 1 || vwen_q[0] !== 4'b1111 || vwen !== 4'b0000) begin
         miscompares++;
         $display("FAIL load_all vwen: at_done=%b after=%b want 1111/0000",
                  (vwen_q.size() > 0) ? vwen_q[0] : 4'b0, vwen);
      end
      collect_granted();
      vectors++;
      if (act_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL load_all req_count: got %0d want %0d", act_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            vectors++;
            if (act_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL load_all req[%0d]: got %h want %h", i, act_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_masked();
      logic [NL*ELEN-1:0] a;
      bit ok;
      gnt_wait = 0; rv_delay = 0; spurious = 1'b0;
      a = rand_vec();
      start_op(1'b0, a, 4'b0000, rand_vec());
      wait_done(20, ok);
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (!ok || done_lat_q.size() != 1 || done_lat_q[0] != 1) begin
         miscompares++;
         $display("FAIL masked done: pulses=%0d cycle=%0d want 1 pulse at 1", done_lat_q.size(),
                  (done_lat_q.size() > 0) ? done_lat_q[0] : -1);
      end
      vectors++;
      if (req_log.size() != 0) begin
         miscompares++;
         $display("FAIL masked mem_req: got %0d request cycles want 0", req_log.size());
      end
      vectors++;
      if (xdmem !== '0 || vwen_q.size() != 1 || vwen_q[0] !== 4'b0000) begin
         miscompares++;
         $display("FAIL masked wb: xdmem=%h vwen_at_done=%b want 0/0000", xdmem,
                  (vwen_q.size() > 0) ? vwen_q[0] : 4'bx);
      end
   endtask

   task automatic test_store_sparse();
      logic [NL*ELEN-1:0] a;
      logic [VLEN-1:0]    d;
      bit ok;
      gnt_wait = 0; rv_delay = 0; spurious = 1'b0;
      a = rand_vec();
      d = rand_vec();
      d[1*ELEN +: ELEN] = 32'h11;
      d[3*ELEN +: ELEN] = 32'h33;
      model(1'b1, a, 4'b1010, d, 0, 0);
      start_op(1'b1, a, 4'b1010, d);
      wait_done(50, ok);
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (!ok || done_lat_q.size() != 1 || done_lat_q[0] != 3) begin
         miscompares++;
         $display("FAIL store done: pulses=%0d cycle=%0d want 1 pulse at 3", done_lat_q.size(),
                  (done_lat_q.size() > 0) ? done_lat_q[0] : -1);
      end
      vectors++;
      if (vwen_q.size() != 1 || vwen_q[0] !== 4'b0000) begin
         miscompares++;
         $display("FAIL store vwen: got %b want 0000", (vwen_q.size() > 0) ? vwen_q[0] : 4'bx);
      end
      collect_granted();
      vectors++;
      if (act_q.size() != 2) begin
         miscompares++;
         $display("FAIL store req_count: got %0d want 2", act_q.size());
      end else begin
         foreach (exp_q[i]) begin
            vectors++;
            if (act_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL store req[%0d]: got %h want %h", i, act_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [NL*ELEN-1:0] a;
      bit ok;
      gnt_wait = 3; rv_delay = 2; spurious = 1'b1;
      a = rand_vec();
      model(1'b0, a, 4'b0101, '0, 3, 2);
      start_op(1'b0, a, 4'b0101, rand_vec());
      wait_done(100, ok);
      #1;
      vectors++;
      if (!ok || done_lat_q.size() != 1 || done_lat_q[0] != exp_lat) begin
         miscompares++;
         $display("FAIL stall done: pulses=%0d cycle=%0d want 1 pulse at %0d", done_lat_q.size(),
                  (done_lat_q.size() > 0) ? done_lat_q[0] : -1, exp_lat);
      end
      vectors++;
      if (req_log.size() != 8) begin
         miscompares++;
         $display("FAIL stall req_cycles: got %0d want 8", req_log.size());
      end
      for (int i = 1; i < req_log.size(); i++) begin
         if (!req_log[i-1].gnt) begin
            vectors++;
            if (req_log[i].addr !== req_log[i-1].addr || req_log[i].we !== req_log[i-1].we ||
                req_log[i].wdata !== req_log[i-1].wdata) begin
               miscompares++;
               $display("FAIL stall stable[%0d]: got addr=%h want %h", i, req_log[i].addr, req_log[i-1].addr);
            end
         end
      end
      vectors++;
      if (xdmem !== exp_x) begin
         miscompares++;
         $display("FAIL stall xdmem: got %h want %h", xdmem, exp_x);
      end
      gnt_wait = 0; rv_delay = 0; spurious = 1'b0;
   endtask

   task automatic test_busy_start_reset();
      logic [NL*ELEN-1:0] a;
      logic [VLEN-1:0]    d;
      bit ok;
      gnt_wait = 0; rv_delay = 3; spurious = 1'b0;
      a = rand_vec();
      start_op(1'b0, a, 4'hF, rand_vec());
      start     = 1'b1;
      is_store  = 1'b1;
      lane_vm   = 4'b0011;
      @(negedge clk); #1;
      start = 1'b0;
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, mem_if.mem_req, mem_if.mem_we} !== 4'b0000 || mem_if.mem_addr !== '0 ||
          mem_if.mem_wdata !== '0 || xdmem !== '0 || vwen !== '0) begin
         miscompares++;
         $display("FAIL midreset outputs: busy=%b done=%b req=%b addr=%h xdmem=%h want all 0",
                  busy, done, mem_if.mem_req, mem_if.mem_addr, xdmem);
      end
      repeat (3) @(negedge clk);
      #1;
      collect_granted();
      vectors++;
      if (done_lat_q.size() != 0) begin
         miscompares++;
         $display("FAIL midreset done: got %0d pulses want 0", done_lat_q.size());
      end
      vectors++;
      if (act_q.size() != 1 || act_q[0] !== {1'b0, a[ELEN-1:0], {ELEN{1'b0}}}) begin
         miscompares++;
         $display("FAIL midreset reqs: got %0d requests want 1 load of lane0", act_q.size());
      end
      rst_n = 1'b1;
      rv_delay = 0;
      a = rand_vec();
      d = rand_vec();
      model(1'b0, a, 4'b0110, d, 0, 0);
      start_op(1'b0, a, 4'b0110, d);
      wait_done(50, ok);
      #1;
      vectors++;
      if (!ok || done_lat_q.size() != 1 || done_lat_q[0] != exp_lat || xdmem !== exp_x) begin
         miscompares++;
         $display("FAIL after_reset load: cycle=%0d xdmem=%h want %0d/%h",
                  (done_lat_q.size() > 0) ? done_lat_q[0] : -1, xdmem, exp_lat, exp_x);
      end
   endtask

   task automatic test_random_back_to_back();
      logic [NL*ELEN-1:0] a;
      logic [VLEN-1:0]    d;
      logic [NL-1:0]      vm;
      bit st, ok;
      for (int n = 0; n < 24; n++) begin
         st       = 1'($urandom_range(0, 1));
         vm       = NL'($urandom_range(0, 15));
         a        = rand_vec();
         d        = rand_vec();
         gnt_wait = $urandom_range(0, 2);
         rv_delay = $urandom_range(0, 2);
         spurious = 1'($urandom_range(0, 1));
         model(st, a, vm, d, gnt_wait, rv_delay);
         start_op(st, a, vm, d);
         wait_done(200, ok);
         collect_granted();
         vectors++;
         if (!ok || done_lat_q.size() != 1 || done_lat_q[0] != exp_lat) begin
            miscompares++;
            $display("FAIL rand[%0d] done: cycle=%0d want %0d", n,
                     (done_lat_q.size() > 0) ? done_lat_q[0] : -1, exp_lat);
         end
         vectors++;
         if (xdmem_q.size() != 1 || xdmem_q[0] !== exp_x || vwen_q[0] !== exp_v) begin
            miscompares++;
            $display("FAIL rand[%0d] wb: xdmem=%h vwen=%b want %h/%b", n,
                     (xdmem_q.size() > 0) ? xdmem_q[0] : '0, (vwen_q.size() > 0) ? vwen_q[0] : 4'bx,
                     exp_x, exp_v);
         end
         vectors++;
         if (act_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rand[%0d] req_count: got %0d want %0d", n, act_q.size(), exp_q.size());
         end else begin
            foreach (exp_q[i]) begin
               vectors++;
               if (act_q[i] !== exp_q[i]) begin
                  miscompares++;
                  $display("FAIL rand[%0d] req[%0d]: got %h want %h", n, i, act_q[i], exp_q[i]);
               end
            end
         end
      end
      gnt_wait = 0; rv_delay = 0; spurious = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_all();
      test_masked();
      test_store_sparse();
      test_stall();
      test_busy_start_reset();
      test_random_back_to_back();
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vlsu_sequencer.md
VLSU_SEQUENCER -- requirements
Module: vlsu_sequencer

Interface
REQ-001 Parameter VLEN, default 128, vector register width in bits.
REQ-002 Parameter ELEN, default 32, element and memory word width in bits; lane count NL = VLEN/ELEN, which is 4 by default.
REQ-003 Port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 Port start, input, 1, requests a vector memory operation; sampled only in IDLE.
REQ-006 Port is_store, input, 1, selects the operation: 1 = store, 0 = load.
REQ-007 Port lane_addr, input, NL*ELEN, per-lane byte addresses from the datapath ALU lanes; lane i occupies bits [i*ELEN +: ELEN].
REQ-008 Port lane_vm, input, NL, per-lane active mask; 1 = lane active.
REQ-009 Port st_data, input, VLEN, store data, i.e. vs3; lane i occupies bits [i*ELEN +: ELEN].
REQ-010 Port mem_req, output, 1, memory request valid.
REQ-011 Port mem_we, output, 1, memory write enable, qualified by mem_req.
REQ-012 Port mem_addr, output, ELEN, memory address.
REQ-013 Port mem_wdata, output, ELEN, memory write data.
REQ-014 Port mem_gnt, input, 1, memory accepted the request in this cycle.
REQ-015 Port mem_rvalid, input, 1, load data valid on mem_rdata in this cycle.
REQ-016 Port mem_rdata, input, ELEN, memory read data.
REQ-017 Port busy, output, 1, high in every state other than IDLE.
REQ-018 Port done, output, 1, one-cycle completion pulse.
REQ-019 Port xdmem, output, VLEN, assembled load data for the vector writeback mux.
REQ-020 Port vwen, output, NL, per-lane register-file write enables for load writeback, valid while done is high.

Function
REQ-021 The block SHALL implement the states IDLE, REQ, WAIT and DONE.
REQ-022 In IDLE, when start=1, the block SHALL register is_store, lane_addr, lane_vm and st_data, and SHALL clear the xdmem register to 0.
- If any registered mask bit is 1: the next state SHALL be REQ, with the lane pointer set to the lowest active lane.
- If all mask bits are 0: the next state SHALL be DONE, and no memory request SHALL be issued.
REQ-023 In REQ, mem_req SHALL be 1, mem_addr SHALL equal the registered address of the current lane, mem_we SHALL equal is_store, and mem_wdata SHALL equal that lane's st_data for a store and 0 for a load.
REQ-024 In REQ, all mem_* outputs SHALL be held stable until mem_gnt=1.
REQ-025 On REQ with mem_gnt=1 and a store, the block SHALL advance to the next higher active lane and stay in REQ; if no higher active lane exists, it SHALL go to DONE.
REQ-026 On REQ with mem_gnt=1 and a load, the block SHALL go to WAIT.
REQ-027 In WAIT, mem_req SHALL be 0.
REQ-028 In WAIT, when mem_rvalid=1, the block SHALL write mem_rdata into the current lane's slice of xdmem, then advance to the next active lane in REQ, or go to DONE if no active lane remains.
REQ-029 mem_rvalid SHALL be ignored in every state other than WAIT.
REQ-030 Inactive lanes SHALL never be requested; their xdmem slice SHALL remain 0.
REQ-031 In DONE, done SHALL be 1 for exactly one cycle, after which the state SHALL return to IDLE.
REQ-032 vwen SHALL equal the registered lane_vm while done is high on a load, and SHALL be 0 otherwise, including on every store.
REQ-033 xdmem SHALL hold its value from DONE until the next accepted start.
REQ-034 start SHALL be ignored while busy=1; in-flight state and outputs SHALL be unaffected.
REQ-035 Lane order SHALL be ascending from lane 0; each memory access SHALL be exactly one ELEN-wide word.
REQ-036 Address arithmetic SHALL NOT be performed in this block; addresses SHALL pass through unmodified.
REQ-037 Latency with zero-wait memory (mem_gnt in the same cycle as mem_req, mem_rvalid one cycle later), with start in cycle 0 and N active lanes:
- Load: done SHALL be high in cycle 2N+1.
- Store: done SHALL be high in cycle N+1.
- All lanes masked: done SHALL be high in cycle 1.

Reset
REQ-038 While rst_n=0, the block SHALL force state IDLE, lane pointer 0, busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, xdmem=0 and vwen=0, independent of clk.
REQ-039 A reset asserted mid-operation SHALL abandon the operation with no done pulse and no further memory requests.
REQ-040 After rst_n is released, the first clk edge SHALL evaluate start in IDLE.

Verification
REQ-041 Load, all 4 lanes active, addresses 0x100/0x104/0x108/0x10C, zero-wait memory returning 0xA0..0xA3 -> four requests with mem_we=0 in ascending address order; done high in cycle 9; xdmem=0x000000A3_000000A2_000000A1_000000A0; vwen=4'b1111.
REQ-042 Store with lane_vm=4'b1010 and st_data lane1=0x11, lane3=0x33 -> exactly two writes, to lane1 then lane3 addresses with data 0x11 then 0x33; done high in cycle 3; vwen=0.
REQ-043 Load with lane_vm=4'b0000 -> no mem_req; done high in cycle 1; xdmem=0; vwen=0.
REQ-044 Load with mem_gnt held low 3 cycles on lane 0 and mem_rvalid delayed 2 cycles -> mem_addr and mem_req stable while stalled; a spurious mem_rvalid during REQ is ignored; the correct lane data is captured.
REQ-045 A second start pulse while busy, followed by rst_n low during WAIT -> the second start has no effect; reset returns the block to IDLE with all outputs 0, no done pulse; a new load after reset completes normally.
